// File: rtl/led_pio_blink.sv
// ---------------------------------------------------------------------------
// led_pio_blink
//
// Avalon-MM parallel output port for driving LEDs, with a per-bit blink mask.
// The port has a DATA register plus atomic OUTSET/OUTCLR aliases for
// read-modify-write-free bit manipulation. A free-running prescaler toggles a
// common "phase" bit every PERIOD+1 clocks. Bits selected in BLINK_EN show
// DATA gated by that phase. The other bits show DATA directly.
//
// Register map (word address):
//   0 DATA      rw  LED value
//   1 BLINK_EN  rw  per-bit blink enable
//   2 PERIOD    rw  blink half-period minus one, in clk cycles
//   3 STATUS    ro  {31'b0, phase}
//   4 OUTSET    wo  DATA |= writedata (reads 0)
//   5 OUTCLR    wo  DATA &= ~writedata (reads 0)
//   6-7         reserved (read 0, writes ignored)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   address     Avalon-MM word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    combinational read data (zero wait states)
//   out_port    LED drive, decoded from registers only
// ---------------------------------------------------------------------------
module led_pio_blink #(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'd0,
    parameter int          PERIOD_W     = 24,
    parameter logic [31:0] PERIOD_RESET = 32'd12499999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam logic [WIDTH-1:0]    DATA_INIT   = RESET_VALUE[WIDTH-1:0];
    localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_RESET[PERIOD_W-1:0];

    logic wr_en;
    logic wr_data;
    logic wr_blink;
    logic wr_period;
    logic wr_set;
    logic wr_clr;

    assign wr_en     = chipselect && !write_n;
    assign wr_data   = wr_en && (address == ADDR_DATA);
    assign wr_blink  = wr_en && (address == ADDR_BLINK_EN);
    assign wr_period = wr_en && (address == ADDR_PERIOD);
    assign wr_set    = wr_en && (address == ADDR_OUTSET);
    assign wr_clr    = wr_en && (address == ADDR_OUTCLR);

    // Only the low WIDTH / PERIOD_W bits of writedata are stored. This
    // reduction keeps the remaining bits formally consumed.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    logic [WIDTH-1:0]    wdata_w;
    logic [PERIOD_W-1:0] wdata_p;

    assign wdata_w = writedata[WIDTH-1:0];
    assign wdata_p = writedata[PERIOD_W-1:0];

    // -----------------------------------------------------------------------
    // Register state
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]    data_reg,     data_next;
    logic [WIDTH-1:0]    blink_en_reg, blink_en_next;
    logic [PERIOD_W-1:0] period_reg,   period_next;
    logic [PERIOD_W-1:0] cnt_reg,      cnt_next;
    logic                phase_reg,    phase_next;

    // DATA, BLINK_EN and PERIOD next-state. The address decode is one-hot,
    // so at most one of these branches is taken in a cycle.
    always_comb begin
        data_next     = data_reg;
        blink_en_next = blink_en_reg;
        period_next   = period_reg;

        if (wr_data) begin
            data_next = wdata_w;
        end else if (wr_set) begin
            data_next = data_reg | wdata_w;
        end else if (wr_clr) begin
            data_next = data_reg & ~wdata_w;
        end

        if (wr_blink) begin
            blink_en_next = wdata_w;
        end

        if (wr_period) begin
            period_next = wdata_p;
        end
    end

    // Prescaler and phase.
    // A PERIOD or BLINK_EN write restarts the half-period from the top. It
    // also overrides a coincident expiry, so software always gets a full
    // PERIOD+1 cycles after reprogramming. A BLINK_EN write also starts with
    // phase = 1, so newly enabled LEDs light immediately.
    always_comb begin
        cnt_next   = cnt_reg;
        phase_next = phase_reg;

        if (wr_period) begin
            cnt_next = wdata_p;
        end else if (wr_blink) begin
            cnt_next   = period_reg;
            phase_next = 1'b1;
        end else if (cnt_reg == '0) begin
            cnt_next   = period_reg;
            phase_next = ~phase_reg;
        end else begin
            cnt_next = cnt_reg - PERIOD_W'(1);
        end
    end

    // Reset takes priority, so a bus write in the same cycle as reset is
    // discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg     <= DATA_INIT;
            blink_en_reg <= '0;
            period_reg   <= PERIOD_INIT;
            cnt_reg      <= PERIOD_INIT;
            phase_reg    <= 1'b1;
        end else begin
            data_reg     <= data_next;
            blink_en_reg <= blink_en_next;
            period_reg   <= period_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux. This path is purely combinational and has no side effects.
    // Write-only and reserved addresses read as zero.
    // -----------------------------------------------------------------------
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_reg);
            ADDR_BLINK_EN: readdata = 32'(blink_en_reg);
            ADDR_PERIOD:   readdata = 32'(period_reg);
            ADDR_STATUS:   readdata = {31'd0, phase_reg};
            default:       readdata = 32'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // LED drive. Each bit is decoded from registers only, so bus activity
    // cannot glitch the pins.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_out
            assign out_port[gi] = blink_en_reg[gi] ? (data_reg[gi] & phase_reg)
                                                   : data_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_led_pio_blink.sv
// ---------------------------------------------------------------------------
// tb_led_pio_blink
//
// Self-checking bench for led_pio_blink (WIDTH=8, RESET_VALUE=8'hA5, default
// prescaler). Every cycle the DUT outputs are compared against a behavioural
// model. The model derives phase arithmetically: phase is the phase at the
// last counter (re)load, flipped once per elapsed PERIOD+1 edges.
// Table-driven register vectors and hand sequences with constant expectations
// cover the blink timing and corner cases.
// ---------------------------------------------------------------------------
module tb_led_pio_blink;

    localparam int          WIDTH = 8;
    localparam logic [31:0] RV    = 32'h000000A5;
    localparam logic [31:0] PR    = 32'd12499999;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [WIDTH-1:0] out_port;

    led_pio_blink #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .PERIOD_W    (24),
        .PERIOD_RESET(PR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_data;
    logic [7:0]  m_blink;
    logic [23:0] m_period;
    logic        m_p0;      // phase right after last counter load
    longint      m_P;       // period value loaded at that time
    longint      m_k;       // edges since that load

    function automatic logic m_phase();
        return m_p0 ^ logic'((m_k / (m_P + 1)) % 2);
    endfunction

    function automatic logic [7:0] m_out();
        logic ph;
        ph = m_phase();
        return m_data & ~(m_blink & {8{~ph}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd1:    return {24'd0, m_blink};
            3'd2:    return {8'd0, m_period};
            3'd3:    return {31'd0, m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic wr,
                              input logic [2:0] a, input logic [31:0] wd);
        logic load;
        logic ph;
        load = 1'b0;
        if (rst) begin
            m_data = RV[7:0]; m_blink = 8'd0; m_period = PR[23:0];
            m_p0 = 1'b1; m_P = longint'(PR); m_k = 0;
        end else begin
            ph = m_phase();
            if (wr) begin
                case (a)
                    3'd0: m_data = wd[7:0];
                    3'd1: begin
                        m_blink = wd[7:0];
                        load = 1'b1; m_p0 = 1'b1; m_P = longint'(m_period);
                    end
                    3'd2: begin
                        m_period = wd[23:0];
                        load = 1'b1; m_p0 = ph; m_P = longint'(wd[23:0]);
                    end
                    3'd4: m_data = m_data | wd[7:0];
                    3'd5: m_data = m_data & ~wd[7:0];
                    default: ;
                endcase
            end
            if (load) m_k = 0;
            else      m_k = m_k + 1;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One bus cycle: drive inputs, clock, update model, then compare out_port
    // and readdata at read address ra against the model.
    task automatic cycle(input logic rst, input logic cs, input logic wn,
                         input logic [2:0] a, input logic [31:0] wd,
                         input logic [2:0] ra);
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
        @(posedge clk);
        model_edge(rst, cs && !wn, a, wd);
        #1;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = ra;
        #1;
        txn++;
        $display("txn %0d rst=%0b cs=%0b wn=%0b addr=%0d wd=%h | out=%h rd[%0d]=%h",
                 txn, rst, cs, wn, a, wd, out_port, ra, readdata);
        check("out_port", {24'd0, out_port}, {24'd0, m_out()});
        check("readdata", readdata, m_read(ra));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cycle(1'b0, 1'b1, 1'b0, a, wd, 3'd3);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 3'd3);
    endtask

    task automatic chk_read(input string name, input logic [2:0] a,
                            input logic [31:0] exp);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        check(name, readdata, exp);
    endtask

    typedef struct {
        logic        cs;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 3'd0, 32'h000000F0, 3'd0, 32'h000000F0};
        tbl[1] = '{1'b1, 3'd4, 32'h0000000F, 3'd0, 32'h000000FF};
        tbl[2] = '{1'b1, 3'd5, 32'h00000081, 3'd0, 32'h0000007E};
        tbl[3] = '{1'b1, 3'd3, 32'hFFFFFFFF, 3'd4, 32'h00000000};
        tbl[4] = '{1'b1, 3'd6, 32'h12345678, 3'd5, 32'h00000000};
        tbl[5] = '{1'b1, 3'd7, 32'h000000FF, 3'd6, 32'h00000000};
        tbl[6] = '{1'b0, 3'd0, 32'h00000000, 3'd0, 32'h0000007E};
        tbl[7] = '{1'b1, 3'd7, 32'h00000000, 3'd7, 32'h00000000};
        tbl[8] = '{1'b1, 3'd3, 32'h00000000, 3'd0, 32'h0000007E};
        tbl[9] = '{1'b0, 3'd2, 32'h00000005, 3'd2, PR};

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 32'd0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 3'd3);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'hFF, 3'd3);
        check("reset_out", {24'd0, out_port}, 32'h000000A5);
        chk_read("reset_data", 3'd0, 32'h000000A5);
        chk_read("reset_period", 3'd2, 32'd12499999);
        chk_read("reset_status", 3'd3, 32'd1);

        // Register vectors
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, tbl[i].cs, 1'b0, tbl[i].addr, tbl[i].wd, tbl[i].ra);
            check($sformatf("vec%0d", i), readdata, tbl[i].exp);
        end

        // Blink: PERIOD=3, DATA=3, BLINK_EN=1
        wr(3'd2, 32'd3);
        wr(3'd0, 32'h03);
        wr(3'd1, 32'h01);
        check("blink_start", {31'd0, out_port[0]}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            idle();
            check($sformatf("blink_b0_%0d", i), {31'd0, out_port[0]},
                  (((i / 4) % 2) == 0) ? 32'd1 : 32'd0);
            check($sformatf("blink_b1_%0d", i), {31'd0, out_port[1]}, 32'd1);
        end

        // PERIOD=0: phase toggles every cycle
        wr(3'd2, 32'd0);
        wr(3'd1, 32'h00);
        check("p0_start", readdata, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            idle();
            check($sformatf("p0_tog_%0d", i), readdata,
                  ((i % 2) == 0) ? 32'd1 : 32'd0);
        end

        // PERIOD write on the exact expiry edge suppresses the toggle
        wr(3'd2, 32'd3);
        wr(3'd1, 32'h00);
        for (int i = 1; i <= 3; i++) begin
            idle();
            check($sformatf("exp_pre_%0d", i), readdata, 32'd1);
        end
        wr(3'd2, 32'd2);
        check("exp_suppress", readdata, 32'd1);
        idle(); check("exp_post_1", readdata, 32'd1);
        idle(); check("exp_post_2", readdata, 32'd1);
        idle(); check("exp_post_3", readdata, 32'd0);

        // Reset mid-blink with a coincident DATA write of FF
        wr(3'd1, 32'hFF);
        idle(); idle(); idle();
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'hFF, 3'd3);
        check("rst_mid_status", readdata, 32'd1);
        chk_read("rst_mid_data", 3'd0, 32'h000000A5);
        chk_read("rst_mid_blink", 3'd1, 32'd0);
        chk_read("rst_mid_period", 3'd2, 32'd12499999);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("rst_mid_hold", readdata, 32'd1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        r_rst;
            logic        r_cs;
            logic        r_wn;
            logic [2:0]  r_a;
            logic [31:0] r_wd;
            logic [2:0]  r_ra;
            r_rst = ($urandom_range(0, 99) == 0);
            r_cs  = ($urandom_range(0, 3) != 0);
            r_wn  = ($urandom_range(0, 2) == 0);
            r_a   = 3'($urandom_range(0, 7));
            r_wd  = $urandom;
            if (r_a == 3'd2) r_wd = $urandom_range(0, 7);
            r_ra  = 3'($urandom_range(0, 7));
            cycle(r_rst, r_cs, r_wn, r_a, r_wd, r_ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
